// File: rtl/smi_req_frame_router.sv
// Steers SMI request frames to the read or write path by the type byte of the first flit.
// Unknown frame types are swallowed and counted; each output path has a 2-entry FIFO.
module smi_req_frame_router #(
  parameter int unsigned DataIndexSize = 3,
  parameter logic [7:0]  ReadReqId     = 8'h01,
  parameter logic [7:0]  WriteReqId    = 8'h02,
  localparam int unsigned DataWidth    = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 smiRdReady,
  output logic [7:0]           smiRdEofc,
  output logic [DataWidth-1:0] smiRdData,
  input  logic                 smiRdStop,
  output logic                 smiWrReady,
  output logic [7:0]           smiWrEofc,
  output logic [DataWidth-1:0] smiWrData,
  input  logic                 smiWrStop,
  output logic [15:0]          dropCount
);

  localparam int unsigned EntryWidth = DataWidth + 8;

  typedef enum logic [1:0] {
    StIdle,
    StRouteRd,
    StRouteWr,
    StDiscard
  } state_e;

  state_e state_q, state_d;

  // Path index 0 is the read path, index 1 the write path.
  logic [1:0]                 push;
  logic [1:0]                 pop;
  logic [1:0]                 full;
  logic [1:0]                 out_valid;
  logic [1:0]                 down_stop;
  logic [1:0][EntryWidth-1:0] head;
  logic [EntryWidth-1:0]      in_entry;

  logic        req_stop;
  logic        accept;
  logic        last_flit;
  logic        drop_inc;
  logic [15:0] drop_q, drop_d;

  assign in_entry  = {smiReqEofc, smiReqData};
  assign down_stop = {smiWrStop, smiRdStop};

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [1:0]            cnt_q, cnt_d;
    logic [EntryWidth-1:0] slot0_q, slot0_d;
    logic [EntryWidth-1:0] slot1_q, slot1_d;

    assign out_valid[p] = (cnt_q != 2'd0);
    assign full[p]      = (cnt_q == 2'd2);
    assign pop[p]       = out_valid[p] & ~down_stop[p];
    assign head[p]      = slot0_q;

    // slot0 is always the head entry; slot1 shifts forward on pop.
    always_comb begin
      cnt_d   = cnt_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      unique case ({push[p], pop[p]})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            slot0_d = in_entry;
          end else begin
            slot1_d = in_entry;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b11: begin
          slot0_d = (cnt_q == 2'd1) ? in_entry : slot1_q;
          slot1_d = in_entry;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (srst) begin
        cnt_q <= 2'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Payload needs no reset: it is only observed while the count is nonzero.
    always_ff @(posedge clk) begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign last_flit = (smiReqEofc != 8'd0);

  always_comb begin
    state_d  = state_q;
    push     = 2'b00;
    drop_inc = 1'b0;
    req_stop = 1'b0;

    // Stop depends only on registered state so no combinational path reaches upstream.
    unique case (state_q)
      StIdle:    req_stop = full[0] | full[1];
      StRouteRd: req_stop = full[0];
      StRouteWr: req_stop = full[1];
      default:   req_stop = 1'b0;
    endcase

    accept = smiReqReady & ~req_stop;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (smiReqData[7:0] == ReadReqId) begin
            push[0] = 1'b1;
            if (!last_flit) state_d = StRouteRd;
          end else if (smiReqData[7:0] == WriteReqId) begin
            push[1] = 1'b1;
            if (!last_flit) state_d = StRouteWr;
          end else begin
            drop_inc = 1'b1;
            if (!last_flit) state_d = StDiscard;
          end
        end
        StRouteRd: begin
          push[0] = 1'b1;
          if (last_flit) state_d = StIdle;
        end
        StRouteWr: begin
          push[1] = 1'b1;
          if (last_flit) state_d = StIdle;
        end
        default: begin
          if (last_flit) state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= StIdle;
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  assign smiReqStop             = req_stop;
  assign smiRdReady             = out_valid[0];
  assign {smiRdEofc, smiRdData} = head[0];
  assign smiWrReady             = out_valid[1];
  assign {smiWrEofc, smiWrData} = head[1];
  assign dropCount              = drop_q;

endmodule

// File: tb/tb_smi_req_frame_router.sv
// Directed bench for smi_req_frame_router: per-cycle vector table plus reset and
// drop-counter saturation sequences.
module tb_smi_req_frame_router;

  logic        clk;
  logic        srst;
  logic        smiReqReady;
  logic [7:0]  smiReqEofc;
  logic [63:0] smiReqData;
  logic        smiReqStop;
  logic        smiRdReady;
  logic [7:0]  smiRdEofc;
  logic [63:0] smiRdData;
  logic        smiRdStop;
  logic        smiWrReady;
  logic [7:0]  smiWrEofc;
  logic [63:0] smiWrData;
  logic        smiWrStop;
  logic [15:0] dropCount;

  int checks;
  int errors;

  smi_req_frame_router dut (
    .clk         (clk),
    .srst        (srst),
    .smiReqReady (smiReqReady),
    .smiReqEofc  (smiReqEofc),
    .smiReqData  (smiReqData),
    .smiReqStop  (smiReqStop),
    .smiRdReady  (smiRdReady),
    .smiRdEofc   (smiRdEofc),
    .smiRdData   (smiRdData),
    .smiRdStop   (smiRdStop),
    .smiWrReady  (smiWrReady),
    .smiWrEofc   (smiWrEofc),
    .smiWrData   (smiWrData),
    .smiWrStop   (smiWrStop),
    .dropCount   (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for the cycle, and the outputs expected while those inputs are presented
  // (i.e. before that cycle's clock edge).
  typedef struct {
    logic        rdy;
    logic [7:0]  eofc;
    logic [63:0] data;
    logic        rs;
    logic        ws;
    logic        stp;
    logic        rr;
    logic [7:0]  re;
    logic [63:0] rdat;
    logic        wr;
    logic [7:0]  we;
    logic [63:0] wdat;
    logic [15:0] dc;
  } vec_t;

  localparam int NumVec = 31;
  vec_t vecs [NumVec];

  localparam logic [63:0] R0 = 64'hA5A5_0000_1234_0001;
  localparam logic [63:0] W0 = 64'hC0DE_0000_0000_0002;
  localparam logic [63:0] W1 = 64'hC0DE_0001_0000_0001;
  localparam logic [63:0] W2 = 64'hC0DE_0002_0000_00FF;
  localparam logic [63:0] W3 = 64'hC0DE_0003_0000_0002;
  localparam logic [63:0] U0 = 64'h0000_0000_0000_007F;
  localparam logic [63:0] U1 = 64'h7777_0000_0000_0002;
  localparam logic [63:0] U2 = 64'h7777_0000_0000_0001;
  localparam logic [63:0] R1 = 64'hBEEF_0000_0000_0001;
  localparam logic [63:0] B0 = 64'hB000_0000_0000_0002;
  localparam logic [63:0] B1 = 64'hB001_0000_0000_0011;
  localparam logic [63:0] B2 = 64'hB002_0000_0000_0022;
  localparam logic [63:0] B3 = 64'hB003_0000_0000_0001;
  localparam logic [63:0] B4 = 64'hB004_0000_0000_0044;
  localparam logic [63:0] C0 = 64'hC000_0000_0000_0002;
  localparam logic [63:0] C1 = 64'hC100_0000_0000_0002;
  localparam logic [63:0] RR = 64'hD00D_0000_0000_0001;
  localparam logic [63:0] Z  = 64'h0;

  function automatic vec_t mk(input logic rdy, input logic [7:0] eofc, input logic [63:0] data,
                              input logic rs, input logic ws, input logic stp,
                              input logic rr, input logic [7:0] re, input logic [63:0] rdat,
                              input logic wr, input logic [7:0] we, input logic [63:0] wdat,
                              input logic [15:0] dc);
    vec_t v;
    v.rdy = rdy; v.eofc = eofc; v.data = data; v.rs = rs; v.ws = ws;
    v.stp = stp; v.rr = rr; v.re = re; v.rdat = rdat;
    v.wr = wr; v.we = we; v.wdat = wdat; v.dc = dc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //               rdy eofc data rs ws | stp rr re rdat  wr we wdat dc
    vecs[0]  = mk(0, 8'd0, Z,  0, 0, 0, 0, 0, Z,  0, 0, Z,  0); // reset state
    vecs[1]  = mk(1, 8'd8, R0, 0, 0, 0, 0, 0, Z,  0, 0, Z,  0); // single-flit read
    vecs[2]  = mk(0, 8'd0, Z,  0, 0, 0, 1, 8, R0, 0, 0, Z,  0);
    vecs[3]  = mk(1, 8'd0, W0, 0, 0, 0, 0, 0, Z,  0, 0, Z,  0); // 4-flit write
    vecs[4]  = mk(1, 8'd0, W1, 0, 0, 0, 0, 0, Z,  1, 0, W0, 0);
    vecs[5]  = mk(1, 8'd0, W2, 0, 0, 0, 0, 0, Z,  1, 0, W1, 0);
    vecs[6]  = mk(1, 8'd8, W3, 0, 0, 0, 0, 0, Z,  1, 0, W2, 0);
    vecs[7]  = mk(0, 8'd0, Z,  0, 0, 0, 0, 0, Z,  1, 8, W3, 0);
    vecs[8]  = mk(1, 8'd0, U0, 0, 0, 0, 0, 0, Z,  0, 0, Z,  0); // unknown 3-flit
    vecs[9]  = mk(1, 8'd0, U1, 0, 0, 0, 0, 0, Z,  0, 0, Z,  1);
    vecs[10] = mk(1, 8'd4, U2, 0, 0, 0, 0, 0, Z,  0, 0, Z,  1);
    vecs[11] = mk(1, 8'd8, R1, 0, 0, 0, 0, 0, Z,  0, 0, Z,  1); // read right after
    vecs[12] = mk(0, 8'd0, Z,  0, 0, 0, 1, 8, R1, 0, 0, Z,  1);
    vecs[13] = mk(0, 8'd0, Z,  0, 1, 0, 0, 0, Z,  0, 0, Z,  1);
    vecs[14] = mk(1, 8'd0, B0, 0, 1, 0, 0, 0, Z,  0, 0, Z,  1); // 5-flit write, wr stop
    vecs[15] = mk(1, 8'd0, B1, 0, 1, 0, 0, 0, Z,  1, 0, B0, 1);
    vecs[16] = mk(1, 8'd0, B2, 0, 1, 1, 0, 0, Z,  1, 0, B0, 1);
    vecs[17] = mk(1, 8'd0, B2, 0, 1, 1, 0, 0, Z,  1, 0, B0, 1);
    vecs[18] = mk(1, 8'd0, B2, 0, 0, 1, 0, 0, Z,  1, 0, B0, 1);
    vecs[19] = mk(1, 8'd0, B2, 0, 0, 0, 0, 0, Z,  1, 0, B1, 1);
    vecs[20] = mk(1, 8'd0, B3, 0, 0, 0, 0, 0, Z,  1, 0, B2, 1);
    vecs[21] = mk(1, 8'd8, B4, 0, 0, 0, 0, 0, Z,  1, 0, B3, 1);
    vecs[22] = mk(0, 8'd0, Z,  0, 0, 0, 0, 0, Z,  1, 8, B4, 1);
    vecs[23] = mk(0, 8'd0, Z,  0, 0, 0, 0, 0, Z,  0, 0, Z,  1);
    vecs[24] = mk(1, 8'd8, C0, 0, 1, 0, 0, 0, Z,  0, 0, Z,  1); // fill write FIFO
    vecs[25] = mk(1, 8'd8, C1, 0, 1, 0, 0, 0, Z,  1, 8, C0, 1);
    vecs[26] = mk(1, 8'd8, RR, 0, 1, 1, 0, 0, Z,  1, 8, C0, 1); // read blocked in Idle
    vecs[27] = mk(1, 8'd8, RR, 0, 0, 1, 0, 0, Z,  1, 8, C0, 1);
    vecs[28] = mk(1, 8'd8, RR, 0, 0, 0, 0, 0, Z,  1, 8, C1, 1);
    vecs[29] = mk(0, 8'd0, Z,  0, 0, 0, 1, 8, RR, 0, 0, Z,  1);
    vecs[30] = mk(0, 8'd0, Z,  0, 0, 0, 0, 0, Z,  0, 0, Z,  1);

    srst        = 1'b1;
    smiReqReady = 1'b0;
    smiReqEofc  = 8'd0;
    smiReqData  = 64'd0;
    smiRdStop   = 1'b0;
    smiWrStop   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      smiReqReady = vecs[i].rdy;
      smiReqEofc  = vecs[i].eofc;
      smiReqData  = vecs[i].data;
      smiRdStop   = vecs[i].rs;
      smiWrStop   = vecs[i].ws;
      #1;
      cmp($sformatf("v%0d req_stop", i), 64'(smiReqStop), 64'(vecs[i].stp));
      cmp($sformatf("v%0d rd_ready", i), 64'(smiRdReady), 64'(vecs[i].rr));
      cmp($sformatf("v%0d wr_ready", i), 64'(smiWrReady), 64'(vecs[i].wr));
      cmp($sformatf("v%0d drop_count", i), 64'(dropCount), 64'(vecs[i].dc));
      if (vecs[i].rr) begin
        cmp($sformatf("v%0d rd_eofc", i), 64'(smiRdEofc), 64'(vecs[i].re));
        cmp($sformatf("v%0d rd_data", i), smiRdData, vecs[i].rdat);
      end
      if (vecs[i].wr) begin
        cmp($sformatf("v%0d wr_eofc", i), 64'(smiWrEofc), 64'(vecs[i].we));
        cmp($sformatf("v%0d wr_data", i), smiWrData, vecs[i].wdat);
      end
    end

    // Reset in the middle of a write frame, after two of four flits.
    @(negedge clk);
    smiWrStop   = 1'b1;
    smiReqReady = 1'b1;
    smiReqEofc  = 8'd0;
    smiReqData  = 64'hE000_0000_0000_0002;
    @(negedge clk);
    smiReqData  = 64'hE001_0000_0000_0033;
    @(negedge clk);
    smiReqReady = 1'b0;
    srst        = 1'b1;
    @(negedge clk);
    srst        = 1'b0;
    smiWrStop   = 1'b0;
    #1;
    cmp("rst rd_ready", 64'(smiRdReady), 64'd0);
    cmp("rst wr_ready", 64'(smiWrReady), 64'd0);
    cmp("rst req_stop", 64'(smiReqStop), 64'd0);
    cmp("rst drop_count", 64'(dropCount), 64'd0);
    smiReqReady = 1'b1;
    smiReqEofc  = 8'd8;
    smiReqData  = 64'hF00D_0000_0000_0001;
    @(negedge clk);
    smiReqReady = 1'b0;
    #1;
    cmp("post-rst rd_ready", 64'(smiRdReady), 64'd1);
    cmp("post-rst rd_data", smiRdData, 64'hF00D_0000_0000_0001);
    cmp("post-rst wr_ready", 64'(smiWrReady), 64'd0);

    // Back-to-back single-flit unknown frames until the drop counter saturates.
    smiReqReady = 1'b1;
    smiReqEofc  = 8'd1;
    smiReqData  = 64'h0000_0000_0000_00FE;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    cmp("sat drop_count 65534", 64'(dropCount), 64'hFFFE);
    cmp("sat req_stop", 64'(smiReqStop), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp("sat drop_count 65535", 64'(dropCount), 64'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    smiReqReady = 1'b0;
    #1;
    cmp("sat drop_count held", 64'(dropCount), 64'hFFFF);
    cmp("sat rd_ready", 64'(smiRdReady), 64'd0);
    cmp("sat wr_ready", 64'(smiWrReady), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
